ehr_fifo: RTL and testbench

EHR_FIFO -- requirements
Module: ehr_fifo

---
 rtl/ehr_fifo.sv | 69 ++++++
 tb/tb_ehr_fifo.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ehr_fifo.sv
// ehr_fifo: parameterised FIFO with pipeline, bypass or conflict-free enq/deq scheduling
module ehr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int MODE = 0,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid,
  input  logic [WIDTH-1:0] enq_data,
  output logic             enq_ready,
  output logic             deq_valid,
  output logic [WIDTH-1:0] deq_data,
  input  logic             deq_ready,
  input  logic             clear,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic empty, full, enq_fire, deq_fire, bypass, do_enq, do_deq;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // handshake: MODE 0 lets enq see the deq port, MODE 1 lets deq see the enq port, MODE 2 sees registers only
  always_comb begin
    empty = rst || (count_q == '0);
    full = !rst && (count_q == CW'(DEPTH));
    deq_valid = (MODE == 1) ? (!empty || enq_valid) : !empty;
    deq_fire = deq_valid && deq_ready;
    enq_ready = (MODE == 0) ? (!full || deq_fire) : !full;
    enq_fire = enq_valid && enq_ready;
    deq_data = (MODE == 1 && empty) ? enq_data : mem_q[head_q];
    bypass = (MODE == 1) && empty && deq_fire;
  end

  // next state: deq/enq ports in mode order, clear applied last and overriding both
  always_comb begin
    do_enq = enq_fire && !bypass;
    do_deq = deq_fire && !bypass;
    head_d = clear ? '0 : (do_deq ? nxt(head_q) : head_q);
    tail_d = clear ? '0 : (do_enq ? nxt(tail_q) : tail_q);
    count_d = clear ? '0 : count_q + CW'(do_enq) - CW'(do_deq);
  end

  // pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end

  // storage write at the tail; contents need no reset
  always_ff @(posedge clk) begin
    if (!rst && do_enq) mem_q[tail_q] <= enq_data;
  end

  assign count = count_q;
endmodule

// File: tb/tb_ehr_fifo.sv
// tb_ehr_fifo: randomized and directed scoreboard bench over all three modes and a non-power-of-two depth
module tb_ehr_fifo;
  logic clk = 0;
  always #5 clk = ~clk;

  int md [4] = '{0, 1, 2, 0};
  int dp [4] = '{4, 4, 4, 3};

  logic rs [4], ev [4], dr [4], cl [4], er [4], dv [4];
  logic [7:0] ed [4], dd [4];
  logic [2:0] cn [4];
  logic [1:0] c3;
  assign cn[3] = {1'b0, c3};

  logic p_rs [4], p_ev [4], p_dr [4], p_cl [4];
  logic [7:0] p_ed [4];
  bit purge [4];
  logic [7:0] mdl [4][$];
  logic [7:0] sb [4][$];
  int nchk = 0, nerr = 0;

  ehr_fifo #(.WIDTH(8), .DEPTH(4), .MODE(0)) u0 (.clk(clk), .rst(rs[0]), .enq_valid(ev[0]), .enq_data(ed[0]),
    .enq_ready(er[0]), .deq_valid(dv[0]), .deq_data(dd[0]), .deq_ready(dr[0]), .clear(cl[0]), .count(cn[0]));
  ehr_fifo #(.WIDTH(8), .DEPTH(4), .MODE(1)) u1 (.clk(clk), .rst(rs[1]), .enq_valid(ev[1]), .enq_data(ed[1]),
    .enq_ready(er[1]), .deq_valid(dv[1]), .deq_data(dd[1]), .deq_ready(dr[1]), .clear(cl[1]), .count(cn[1]));
  ehr_fifo #(.WIDTH(8), .DEPTH(4), .MODE(2)) u2 (.clk(clk), .rst(rs[2]), .enq_valid(ev[2]), .enq_data(ed[2]),
    .enq_ready(er[2]), .deq_valid(dv[2]), .deq_data(dd[2]), .deq_ready(dr[2]), .clear(cl[2]), .count(cn[2]));
  ehr_fifo #(.WIDTH(8), .DEPTH(3), .MODE(0)) u3 (.clk(clk), .rst(rs[3]), .enq_valid(ev[3]), .enq_data(ed[3]),
    .enq_ready(er[3]), .deq_valid(dv[3]), .deq_data(dd[3]), .deq_ready(dr[3]), .clear(cl[3]), .count(c3));

  function automatic void chk(string nm, int k, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s dut%0d (mode %0d depth %0d) t=%0t got %0h want %0h", nm, k, md[k], dp[k], $time, act, exp);
    end
  endfunction

  // monitor: every delivered word must be the oldest expected one
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (dv[k] === 1'b1 && dr[k] === 1'b1) begin
        if (sb[k].size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL deq_data dut%0d t=%0t got %0h want nothing (no word expected)", k, $time, dd[k]);
        end else chk("deq_data", k, int'(dd[k]), int'(sb[k].pop_front()));
      end
    end
  end

  task automatic plan(input bit r, input bit v, input logic [7:0] d, input bit rd, input bit c);
    for (int k = 0; k < 4; k++) begin
      p_rs[k] = r; p_ev[k] = v; p_ed[k] = d; p_dr[k] = rd; p_cl[k] = c;
    end
  endtask

  task automatic step();
    bit x_er [4], x_dv [4];
    int x_n [4];
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      bit full, empty, df, ef;
      int n;
      rs[k] = p_rs[k]; ev[k] = p_ev[k]; ed[k] = p_ed[k]; dr[k] = p_dr[k]; cl[k] = p_cl[k];
      if (purge[k]) begin
        sb[k].delete();
        purge[k] = 0;
      end
      n = mdl[k].size();
      x_n[k] = n;
      if (rs[k]) begin
        sb[k].delete();
        mdl[k].delete();
        x_er[k] = 1;
        x_dv[k] = (md[k] == 1) && ev[k];
        if (x_dv[k] && dr[k]) sb[k].push_back(ed[k]);
      end else begin
        full = (n == dp[k]);
        empty = (n == 0);
        x_dv[k] = (md[k] == 1) ? (!empty || ev[k]) : !empty;
        df = x_dv[k] && dr[k];
        x_er[k] = (md[k] == 0) ? (!full || df) : !full;
        ef = ev[k] && x_er[k];
        if (md[k] == 1 && empty && df) sb[k].push_back(ed[k]);
        else begin
          if (ef) begin
            mdl[k].push_back(ed[k]);
            sb[k].push_back(ed[k]);
          end
          if (df) void'(mdl[k].pop_front());
        end
        if (cl[k]) begin
          mdl[k].delete();
          purge[k] = 1;
        end
      end
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("enq_ready", k, int'(er[k]), int'(x_er[k]));
      chk("deq_valid", k, int'(dv[k]), int'(x_dv[k]));
      chk("count", k, int'(cn[k]), x_n[k]);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      rs[k] = 1; ev[k] = 0; ed[k] = 0; dr[k] = 0; cl[k] = 0; purge[k] = 0;
    end
    plan(1, 0, 8'h00, 0, 0);
    repeat (2) step();
    plan(0, 1, 8'h11, 0, 0); step();
    plan(0, 1, 8'h22, 0, 0); step();
    plan(0, 1, 8'h33, 0, 0); step();
    plan(0, 1, 8'h44, 0, 0); step();
    plan(0, 1, 8'h55, 1, 0); step();
    plan(0, 0, 8'h00, 1, 0); repeat (6) step();
    plan(0, 1, 8'hA5, 1, 0); step();
    plan(0, 0, 8'h00, 0, 0); step();
    plan(0, 0, 8'h00, 1, 0); repeat (3) step();
    plan(0, 1, 8'h01, 0, 0); step();
    plan(0, 1, 8'h02, 0, 0); step();
    plan(0, 1, 8'h03, 0, 0); step();
    plan(0, 1, 8'h77, 1, 1); step();
    plan(0, 0, 8'h00, 0, 0); step();
    plan(0, 0, 8'h00, 1, 0); repeat (4) step();
    plan(0, 1, 8'hAA, 0, 0); step();
    plan(0, 1, 8'hBB, 0, 0); step();
    plan(1, 1, 8'hCC, 1, 0); step();
    plan(0, 1, 8'h3C, 0, 0); step();
    plan(0, 0, 8'h00, 1, 0); repeat (2) step();
    plan(0, 1, 8'h80, 0, 0); step();
    for (int i = 0; i < 10; i++) begin
      plan(0, 1, 8'(8'h81 + i), 1, 0);
      step();
    end
    plan(0, 0, 8'h00, 1, 0); repeat (4) step();
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 4; k++) begin
        p_rs[k] = ($urandom_range(0, 199) == 0);
        p_cl[k] = ($urandom_range(0, 59) == 0);
        p_ev[k] = ($urandom_range(0, 3) != 0);
        p_ed[k] = 8'($urandom);
        p_dr[k] = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      end
      step();
    end
    plan(0, 0, 8'h00, 1, 0); repeat (6) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
